// File: rtl/hdd_pkg.sv
// Shared definitions for the HDD block-transfer controller: FSM states,
// sector geometry and ProDOS block-device command/status codes.
package hdd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        FIN,
        ERR
    } state_t;

    localparam int         SECTOR_BYTES    = 512;
    localparam logic [9:0] SECTOR_CNT_FULL = 10'(SECTOR_BYTES);

    localparam logic [7:0] PRODOS_CMD_STATUS = 8'h00;
    localparam logic [7:0] PRODOS_CMD_READ   = 8'h01;
    localparam logic [7:0] PRODOS_CMD_WRITE  = 8'h02;
    localparam logic [7:0] PRODOS_CMD_FORMAT = 8'h03;

    localparam logic [7:0] PRODOS_OK         = 8'h00;
    localparam logic [7:0] PRODOS_IO_ERR     = 8'h27;
    localparam logic [7:0] PRODOS_NO_DEVICE  = 8'h28;
    localparam logic [7:0] PRODOS_WRITE_PROT = 8'h2B;

endpackage

// File: rtl/hdd_xfer_ctrl.sv
// Moves one 512-byte ProDOS block between the HDD sector buffer and the SD host.
// Optional request timeout is enabled by defining HDD_XFER_TIMEOUT_EN.
module hdd_xfer_ctrl
    import hdd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd14_000_000
) (
    input  logic        CLK_14M,
    input  logic        RESET_N,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic [15:0] sector,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_dout,
    output logic [8:0]  ram_addr,
    output logic [7:0]  ram_di,
    output logic        ram_we,
    input  logic [7:0]  ram_do,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    logic [31:0] r_lba;
    logic        r_dir_wr;
    logic        r_sd_rd;
    logic        r_sd_wr;
    logic        r_done;
    logic        r_err;
    logic [9:0]  r_cnt;
    logic [8:0]  r_last_addr;
    logic        r_addr_vld;

    logic        w_xfer;
    logic        w_new_addr;
    logic        w_count;

`ifdef HDD_XFER_TIMEOUT_EN
    logic [23:0] r_tmo;
`else
    logic        w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

    assign w_xfer     = (r_state == XFER);
    // A write sweep counts each distinct address the host presents, not each cycle.
    assign w_new_addr = !r_addr_vld || (sd_buff_addr != r_last_addr);
    assign w_count    = w_xfer && (r_dir_wr ? (!sd_buff_wr && w_new_addr) : sd_buff_wr);

    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_lba       <= 32'h0;
            r_dir_wr    <= 1'b0;
            r_sd_rd     <= 1'b0;
            r_sd_wr     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= 10'd0;
            r_last_addr <= 9'd0;
            r_addr_vld  <= 1'b0;
`ifdef HDD_XFER_TIMEOUT_EN
            r_tmo       <= 24'd0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_count && (r_cnt != SECTOR_CNT_FULL))
                r_cnt <= r_cnt + 10'd1;
            if (w_xfer && r_dir_wr && !sd_buff_wr) begin
                r_last_addr <= sd_buff_addr;
                r_addr_vld  <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (hdd_read || hdd_write) begin
                        r_lba      <= {16'h0, sector};
                        r_dir_wr   <= !hdd_read;
                        r_sd_rd    <= hdd_read;
                        r_sd_wr    <= !hdd_read;
                        r_err      <= 1'b0;
                        r_cnt      <= 10'd0;
                        r_addr_vld <= 1'b0;
`ifdef HDD_XFER_TIMEOUT_EN
                        r_tmo      <= 24'd0;
`endif
                        r_state    <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_state <= XFER;
                    end
`ifdef HDD_XFER_TIMEOUT_EN
                    else if (r_tmo == TIMEOUT_CYCLES - 24'd1) begin
                        r_sd_rd <= 1'b0;
                        r_sd_wr <= 1'b0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ERR;
                    end else begin
                        r_tmo <= r_tmo + 24'd1;
                    end
`endif
                end
                XFER: begin
                    if (!sd_ack) begin
                        r_done <= 1'b1;
                        if (r_cnt == SECTOR_CNT_FULL) begin
                            r_state <= FIN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end
                    end
                end
                FIN:     r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sd_lba       = r_lba;
    assign sd_rd        = r_sd_rd;
    assign sd_wr        = r_sd_wr;
    assign done         = r_done;
    assign err          = r_err;
    assign busy         = (r_state != IDLE);
    assign cpu_halt     = (r_state != IDLE);
    // Buffer port is a pass-through of the host bus only while bytes are moving.
    assign ram_we       = w_xfer && !r_dir_wr && sd_buff_wr;
    assign ram_addr     = w_xfer ? sd_buff_addr : 9'd0;
    assign ram_di       = (w_xfer && !r_dir_wr) ? sd_buff_din : 8'h00;
    assign sd_buff_dout = (w_xfer && r_dir_wr) ? ram_do : 8'h00;

endmodule

// File: tb/tb_hdd_xfer_ctrl.sv
// Directed bench for hdd_xfer_ctrl: request table plus read, write, short,
// busy-request, reset-abort and (with HDD_XFER_TIMEOUT_EN) timeout sequences.
module tb_hdd_xfer_ctrl;

    logic        CLK_14M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        hdd_read = 1'b0;
    logic        hdd_write = 1'b0;
    logic [15:0] sector = 16'h0;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_din = 8'h00;
    logic        sd_buff_wr = 1'b0;
    logic [7:0]  sd_buff_dout;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  ram_do = 8'h00;
    logic        cpu_halt;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    hdd_xfer_ctrl #(.TIMEOUT_CYCLES(24'd100)) dut (
        .CLK_14M(CLK_14M), .RESET_N(RESET_N),
        .hdd_read(hdd_read), .hdd_write(hdd_write), .sector(sector),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout),
        .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err)
    );

    always #5 CLK_14M = ~CLK_14M;

    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[7:0] ^ 8'h5A ^ {7'b0, a[8]};
    endfunction

    // Sector buffer model with one-clock read latency.
    always @(posedge CLK_14M) ram_do <= pat(ram_addr);
    always @(negedge CLK_14M) if (ram_we === 1'b1) we_cnt <= we_cnt + 1;
    always @(negedge CLK_14M) if (done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_14M);
        #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] sec;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_lba;
    } req_vec_t;

    req_vec_t vecs[4];

    initial begin
        int we0, d0, mism, cyc;

        vecs[0] = '{1'b1, 1'b0, 16'h0123, 1'b1, 1'b0, 32'h0000_0123};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 32'h0000_FFFF};
        vecs[2] = '{1'b1, 1'b1, 16'h8001, 1'b1, 1'b0, 32'h0000_8001};
        vecs[3] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 32'h0000_0000};

        // Reset values
        #12;
        chk("rst_lba", sd_lba, 0);
        chk("rst_rdwr", {sd_rd, sd_wr}, 0);
        chk("rst_ram", {ram_we, ram_addr, ram_di}, 0);
        chk("rst_flags", {cpu_halt, busy, done, err}, 0);
        chk("rst_dout", sd_buff_dout, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        chk("idle_dout_zero", sd_buff_dout, 0);

        // Request table: each request, then an empty transfer ending in ERR
        for (int v = 0; v < 4; v++) begin
            hdd_read = vecs[v].rd; hdd_write = vecs[v].wr; sector = vecs[v].sec;
            tick();
            hdd_read = 1'b0; hdd_write = 1'b0;
            chk($sformatf("v%0d_rd", v), sd_rd, vecs[v].exp_rd);
            chk($sformatf("v%0d_wr", v), sd_wr, vecs[v].exp_wr);
            chk($sformatf("v%0d_lba", v), sd_lba, vecs[v].exp_lba);
            chk($sformatf("v%0d_busy", v), {busy, cpu_halt}, 2'b11);
            chk($sformatf("v%0d_err_clr", v), err, 0);
            sd_ack = 1'b1;
            tick();
            chk($sformatf("v%0d_drop", v), {sd_rd, sd_wr}, 0);
            sd_ack = 1'b0;
            tick();
            chk($sformatf("v%0d_err_done", v), {err, done}, 2'b11);
            tick();
            chk($sformatf("v%0d_idle", v), {busy, cpu_halt, done, err}, 4'b0001);
        end

        // Write scenario: full 512-address sweep
        d0 = done_cnt;
        hdd_write = 1'b1; sector = 16'h0042;
        tick();
        hdd_write = 1'b0;
        repeat (2) tick();
        chk("wr_req_held", {sd_rd, sd_wr}, 2'b01);
        sd_ack = 1'b1;
        tick();
        chk("wr_ack_drop", sd_wr, 0);
        mism = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_addr = 9'(i); sd_buff_wr = 1'b0;
            @(negedge CLK_14M);
            if (ram_addr !== 9'(i) || ram_we !== 1'b0) mism++;
            if (i > 0 && sd_buff_dout !== pat(9'(i - 1))) mism++;
            tick();
        end
        sd_ack = 1'b0;
        @(negedge CLK_14M);
        chk("wr_last_dout", sd_buff_dout, pat(9'd511));
        chk("wr_data_mism", mism, 0);
        tick();
        chk("wr_fin", {done, err}, 2'b10);
        tick();
        chk("wr_idle", {busy, cpu_halt, done}, 0);
        chk("wr_done_cnt", done_cnt - d0, 1);
        sd_buff_addr = 9'd0;

        // Read scenario: 512 strobes of data = addr[7:0]
        d0 = done_cnt; we0 = we_cnt;
        hdd_read = 1'b1; sector = 16'h0123;
        tick();
        hdd_read = 1'b0;
        chk("rd_lba", sd_lba, 32'h123);
        chk("rd_halt_rise", cpu_halt, 1);
        repeat (3) tick();
        chk("rd_req_held", {sd_rd, sd_wr}, 2'b10);
        sd_ack = 1'b1;
        tick();
        chk("rd_ack_drop", sd_rd, 0);
        mism = 0;
        for (int i = 0; i < 512; i++) begin
            sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_din = 8'(i);
            @(negedge CLK_14M);
            if (ram_we !== 1'b1 || ram_addr !== 9'(i) || ram_di !== 8'(i)) mism++;
            tick();
        end
        sd_buff_wr = 1'b0; sd_ack = 1'b0;
        @(negedge CLK_14M);
        chk("rd_data_mism", mism, 0);
        chk("rd_we_low_after", ram_we, 0);
        tick();
        chk("rd_fin", {done, err, cpu_halt}, 3'b101);
        tick();
        chk("rd_halt_fall", {cpu_halt, busy, done}, 0);
        chk("rd_ram_idle", {ram_addr, ram_di}, 0);
        tick();
        chk("rd_we_cnt", we_cnt - we0, 512);
        chk("rd_done_cnt", done_cnt - d0, 1);

        // Short transfer: ack falls after 100 strobes
        d0 = done_cnt;
        hdd_read = 1'b1; sector = 16'h0007;
        tick();
        hdd_read = 1'b0; sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_din = 8'(i);
            tick();
        end
        sd_buff_wr = 1'b0; sd_ack = 1'b0;
        tick();
        chk("short_err_done", {err, done}, 2'b11);
        tick();
        chk("short_halt_fall", {cpu_halt, err}, 2'b01);
        chk("short_done_cnt", done_cnt - d0, 1);

        // Write request during a read XFER is ignored, not queued
        d0 = done_cnt;
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0; sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            sd_buff_wr = 1'b1; sd_buff_addr = 9'(i);
            hdd_write = (i == 5);
            tick();
            if (i == 5) chk("busy_wr_ignored", {sd_wr, sd_rd, busy}, 3'b001);
        end
        hdd_write = 1'b0; sd_buff_wr = 1'b0; sd_ack = 1'b0;
        repeat (5) tick();
        chk("busy_no_queue", {busy, sd_wr, sd_rd}, 0);
        chk("busy_single_done", done_cnt - d0, 1);

        // Reset in the middle of XFER
        d0 = done_cnt;
        hdd_read = 1'b1; sector = 16'h0ABC;
        tick();
        hdd_read = 1'b0; sd_ack = 1'b1;
        tick();
        repeat (20) begin
            sd_buff_wr = 1'b1; sd_buff_din = 8'hC3;
            tick();
        end
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_ram", {ram_we, ram_addr, ram_di}, 0);
        chk("rst_mid_flags", {cpu_halt, busy, done, err, sd_rd, sd_wr}, 0);
        chk("rst_mid_lba", sd_lba, 0);
        sd_buff_wr = 1'b0; sd_ack = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (4) tick();
        chk("rst_mid_no_done", done_cnt - d0, 0);
        chk("rst_mid_idle", {busy, cpu_halt, sd_rd}, 0);

        // Reset while requesting drops sd_rd at once
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        chk("rst_req_rd", sd_rd, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_req_drop", {sd_rd, busy}, 0);
        tick();
        RESET_N = 1'b1;
        tick();

`ifdef HDD_XFER_TIMEOUT_EN
        // Timeout: no ack at all
        d0 = done_cnt;
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        cyc = 0;
        while (sd_rd === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        chk("tmo_cycles", cyc, 100);
        chk("tmo_err_done", {err, done}, 2'b11);
        tick();
        chk("tmo_idle", {busy, err}, 2'b01);
        chk("tmo_done_cnt", done_cnt - d0, 1);
`else
        cyc = 0;
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        while (sd_rd === 1'b1 && cyc < 150) begin
            cyc++;
            tick();
        end
        chk("no_tmo_wait", cyc, 150);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        repeat (3) tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
